fetcher: RTL
============

Name: fetcher

Overview:
- Instruction fetch stage directly downstream of the PC unit.
- Accepts one PC request at a time, with its prediction bit.
- Looks the PC up in a direct-mapped instruction cache. On a miss, fetches the 32-bit word from the memory controller.
- Returns the instruction to the PC unit for next-PC prediction, and pushes {inst, pc, predict} to the decoder/instruction queue.
- Aborts in-flight work on a ROB mispredict flush.

Parameters:
- ICACHE_INDEX_BITS, 8, log2 of cache entries (256 entries). Index is addr[ICACHE_INDEX_BITS+1:2].
- ICACHE_TAG_BITS, 30-ICACHE_INDEX_BITS, tag is addr[31:ICACHE_INDEX_BITS+2].

Ports:
- in_clk  input  1  clock.
- in_rst  input  1  reset; synchronous, active-high.
- in_rdy  input  1  global clock enable; when low, all state and outputs hold.
- in_flush_enable  input  1  ROB mispredict flush.
- in_pc_enable  input  1  PC request valid (single-cycle pulse).
- in_pc_addr  input  32  requested instruction address, word-aligned.
- in_pc_predict  input  1  predicted-taken flag travelling with the PC.
- out_pc_last_enable  output  1  pulse: fetched instruction returned to PC unit.
- out_pc_last_inst  output  32  fetched instruction.
- out_pc_stall  output  1  stall to PC unit; combinational, equals in_queue_full.
- out_mc_enable  output  1  memory read request, level, held until served.
- out_mc_addr  output  32  memory read address.
- in_mc_ready  input  1  pulse: in_mc_data valid for out_mc_addr.
- in_mc_data  input  32  instruction word from memory.
- in_queue_full  input  1  instruction queue cannot take another entry after the in-flight one.
- out_queue_enable  output  1  pulse: push entry to instruction queue.
- out_queue_inst  output  32  instruction.
- out_queue_pc  output  32  its address.
- out_queue_predict  output  1  its prediction flag.

Behaviour:
- Reset: state IDLE; every cache valid bit cleared; out_pc_last_enable, out_queue_enable and out_mc_enable all 0; data outputs 0.
- All state changes only on edges where in_rdy=1. When in_rdy=0, outputs keep their registered values; all consumers share in_rdy.
- States:
  - IDLE: accepts a request.
  - MISS: waiting on memory.
- IDLE with in_pc_enable=1 at edge T:
  - Cache lookup is combinational on in_pc_addr; PC and predict are latched.
  - Hit: in cycle T+1, out_pc_last_enable, out_queue_enable and the data outputs are valid for exactly one cycle. State stays IDLE (hit latency 1).
  - Miss: in cycle T+1, out_mc_enable=1 and out_mc_addr=in_pc_addr; state goes to MISS.
- MISS with in_mc_ready=1 at edge U:
  - Cache entry written: valid=1, tag, data.
  - In cycle U+1: out_mc_enable=0, outputs pulse as for a hit, state goes to IDLE.
  - Miss latency is therefore mem latency + 1.
- in_pc_enable while in MISS: protocol violation, ignored. The PC unit issues only after out_pc_last_enable, or after a flush.
- Flush (in_flush_enable=1 at edge F):
  - Highest priority over request, hit and fill.
  - Next cycle: state IDLE, out_mc_enable=0, no output pulses; any concurrent in_pc_enable is dropped.
  - in_mc_ready coincident with the flush may still fill the cache, since the data is correct for its address, but produces no output.
  - The memory controller must drop a request when out_mc_enable deasserts.
  - Cache contents are not invalidated by flush.
- Replacement is direct-mapped overwrite; there is no write-back (instructions are read-only).
- out_pc_stall mirrors in_queue_full the same cycle.
  - The queue asserts full while one slot is still free, so a request already accepted always completes.
  - The fetcher never back-pressures its own outputs.
- Predict flag is passed through unchanged; the fetcher does no prediction.

Decomposition:
- Shared def.v header holds:
  - ADDRESS_WIDTH, INSTRUCTION_WIDTH, TRUE/FALSE, ZERO_ADDR.
  - ICACHE_INDEX_RANGE and ICACHE_TAG_RANGE macros.
  - Fetcher state encodings FETCH_IDLE and FETCH_MISS.
- One sub-module, fetcher_icache:
  - Valid/tag/data arrays.
  - Combinational hit and data read on the lookup address.
  - Synchronous write port.
  - Synchronous reset clears valid.
- The fetcher holds the FSM, latches and output registers.

Test Plan:
- Cold miss: reset, request pc=0x0 predict=0; mc returns 0x00500093 three cycles after out_mc_enable → out_mc_addr=0x0. One cycle after in_mc_ready: out_pc_last_inst = out_queue_inst = 0x00500093, out_queue_pc=0x0, predict=0, single-cycle pulses.
- Hit: re-request pc=0x0 predict=1 → outputs next cycle with 0x00500093 and predict=1; out_mc_enable never asserts.
- Conflict: after filling 0x0, request 0x400 (same index, different tag) → miss; mc data 0x0000006f returned. A subsequent request for 0x0 misses again.
- Flush mid-miss: request 0x8 (miss), assert in_flush_enable two cycles later together with in_mc_ready → no output pulses and out_mc_enable=0 next cycle. A new request for 0x8 then hits, since the fill was allowed.
- in_rdy low for 4 cycles during MISS with in_mc_ready held high → no state change. Completion occurs only after in_rdy returns; outputs appear one enabled cycle later.
- in_queue_full=1 → out_pc_stall=1 in the same cycle. An in-flight miss still delivers its queue push.

Source files
------------

// File: rtl/fetcher_pkg.sv
// Shared widths, cache geometry, FSM encodings and the queue payload for the fetch stage.
package fetcher_pkg;

   localparam int unsigned ADDRESS_WIDTH     = 32;
   localparam int unsigned INSTRUCTION_WIDTH = 32;
   localparam int unsigned ICACHE_INDEX_BITS = 8;
   localparam int unsigned ICACHE_TAG_BITS   = ADDRESS_WIDTH - 2 - ICACHE_INDEX_BITS;
   localparam int unsigned ICACHE_ENTRIES    = 1 << ICACHE_INDEX_BITS;

   // Cache index occupies addr[IDX_HI:IDX_LO]; the tag is everything above it.
   localparam int unsigned ICACHE_IDX_LO = 2;
   localparam int unsigned ICACHE_IDX_HI = ICACHE_INDEX_BITS + 1;
   localparam int unsigned ICACHE_TAG_LO = ICACHE_INDEX_BITS + 2;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;
   localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = '0;

   typedef enum logic {
      FETCH_IDLE = 1'b0,
      FETCH_MISS = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [INSTRUCTION_WIDTH-1:0] inst;
      logic [ADDRESS_WIDTH-1:0]     pc;
      logic                         predict;
   } fetch_entry_t;

endpackage

// File: rtl/fetcher_icache.sv
// Direct-mapped instruction cache: combinational lookup, synchronous fill, valid bits cleared on reset.
module fetcher_icache
   import fetcher_pkg::*;
(
   input  logic                         in_clk,
   input  logic                         in_rst,
   input  logic [ICACHE_INDEX_BITS-1:0] lookup_index,
   input  logic [ICACHE_TAG_BITS-1:0]   lookup_tag,
   output logic                         lookup_hit_c,
   output logic [INSTRUCTION_WIDTH-1:0] lookup_data_c,
   input  logic                         wr_enable,
   input  logic [ICACHE_INDEX_BITS-1:0] wr_index,
   input  logic [ICACHE_TAG_BITS-1:0]   wr_tag,
   input  logic [INSTRUCTION_WIDTH-1:0] wr_data
);

   logic [ICACHE_ENTRIES-1:0]    valid_q;
   logic [ICACHE_TAG_BITS-1:0]   tag_q  [ICACHE_ENTRIES];
   logic [INSTRUCTION_WIDTH-1:0] data_q [ICACHE_ENTRIES];

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         valid_q <= '0;
      end else if (wr_enable) begin
         valid_q[wr_index] <= TRUE;
      end
   end

   // Tag/data storage needs no reset; the valid bit guards it.
   always_ff @(posedge in_clk) begin
      if (wr_enable) begin
         tag_q[wr_index]  <= wr_tag;
         data_q[wr_index] <= wr_data;
      end
   end

   always_comb begin
      lookup_hit_c  = valid_q[lookup_index] && (tag_q[lookup_index] == lookup_tag);
      lookup_data_c = data_q[lookup_index];
   end

endmodule

// File: rtl/fetcher.sv
// Instruction fetch stage: icache lookup, memory refill on miss, result to PC unit and instruction queue.
module fetcher
   import fetcher_pkg::*;
(
   input  logic                         in_clk,
   input  logic                         in_rst,
   input  logic                         in_rdy,
   input  logic                         in_flush_enable,
   input  logic                         in_pc_enable,
   input  logic [ADDRESS_WIDTH-1:0]     in_pc_addr,
   input  logic                         in_pc_predict,
   output logic                         out_pc_last_enable,
   output logic [INSTRUCTION_WIDTH-1:0] out_pc_last_inst,
   output logic                         out_pc_stall,
   output logic                         out_mc_enable,
   output logic [ADDRESS_WIDTH-1:0]     out_mc_addr,
   input  logic                         in_mc_ready,
   input  logic [INSTRUCTION_WIDTH-1:0] in_mc_data,
   input  logic                         in_queue_full,
   output logic                         out_queue_enable,
   output logic [INSTRUCTION_WIDTH-1:0] out_queue_inst,
   output logic [ADDRESS_WIDTH-1:0]     out_queue_pc,
   output logic                         out_queue_predict
);

   fetch_state_t             state_q;
   logic [ADDRESS_WIDTH-1:0] pc_q;
   logic                     predict_q;
   fetch_entry_t             entry_q;
   logic                     pulse_q;
   logic                     mc_enable_q;
   logic [ADDRESS_WIDTH-1:0] mc_addr_q;

   logic                         hit_c;
   logic [INSTRUCTION_WIDTH-1:0] hit_data_c;
   logic                         fill_c;

   // A fill coincident with a flush still lands: the data is correct for its address.
   assign fill_c = in_rdy && !in_rst && (state_q == FETCH_MISS) && in_mc_ready;

   fetcher_icache u_icache (
      .in_clk        (in_clk),
      .in_rst        (in_rst),
      .lookup_index  (in_pc_addr[ICACHE_IDX_HI:ICACHE_IDX_LO]),
      .lookup_tag    (in_pc_addr[ADDRESS_WIDTH-1:ICACHE_TAG_LO]),
      .lookup_hit_c  (hit_c),
      .lookup_data_c (hit_data_c),
      .wr_enable     (fill_c),
      .wr_index      (mc_addr_q[ICACHE_IDX_HI:ICACHE_IDX_LO]),
      .wr_tag        (mc_addr_q[ADDRESS_WIDTH-1:ICACHE_TAG_LO]),
      .wr_data       (in_mc_data)
   );

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_q     <= FETCH_IDLE;
         pc_q        <= ZERO_ADDR;
         predict_q   <= FALSE;
         entry_q     <= '0;
         pulse_q     <= FALSE;
         mc_enable_q <= FALSE;
         mc_addr_q   <= ZERO_ADDR;
      end else if (in_rdy) begin
         pulse_q <= FALSE;
         if (in_flush_enable) begin
            state_q     <= FETCH_IDLE;
            mc_enable_q <= FALSE;
         end else begin
            case (state_q)
               FETCH_IDLE: begin
                  if (in_pc_enable) begin
                     pc_q      <= in_pc_addr;
                     predict_q <= in_pc_predict;
                     if (hit_c) begin
                        entry_q <= '{inst: hit_data_c, pc: in_pc_addr, predict: in_pc_predict};
                        pulse_q <= TRUE;
                     end else begin
                        mc_enable_q <= TRUE;
                        mc_addr_q   <= in_pc_addr;
                        state_q     <= FETCH_MISS;
                     end
                  end
               end
               FETCH_MISS: begin
                  // New requests here are a protocol violation and are ignored.
                  if (in_mc_ready) begin
                     entry_q     <= '{inst: in_mc_data, pc: pc_q, predict: predict_q};
                     pulse_q     <= TRUE;
                     mc_enable_q <= FALSE;
                     state_q     <= FETCH_IDLE;
                  end
               end
               default: state_q <= FETCH_IDLE;
            endcase
         end
      end
   end

   assign out_pc_last_enable = pulse_q;
   assign out_pc_last_inst   = entry_q.inst;
   assign out_queue_enable   = pulse_q;
   assign out_queue_inst     = entry_q.inst;
   assign out_queue_pc       = entry_q.pc;
   assign out_queue_predict  = entry_q.predict;
   assign out_mc_enable      = mc_enable_q;
   assign out_mc_addr        = mc_addr_q;
   assign out_pc_stall       = in_queue_full;

endmodule
